// File: rtl/cpu_mem_bridge.sv
// Bridges the core's single-cycle SRAM-style port onto a valid/ready AXI-lite-style master.
// Stalls the pipeline until the bus transfer completes or times out.
module cpu_mem_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // cpu side
  input  logic                i_cpu_cs,
  input  logic [DATA_W/8-1:0] i_cpu_web,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  output logic                o_cpu_stall,
  output logic                o_cpu_err,
  // read address / data
  output logic [ADDR_W-1:0]   o_araddr,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rvalid,
  output logic                o_rready,
  // write address / data / response
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TMO_W  = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

  typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWr, StWrB, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [DATA_W-1:0]   r_rdata, w_rdata_d;
  logic                r_err, w_err_d;
  logic [TMO_W-1:0]    r_tmo, w_tmo_d;
  logic                r_aw_done, w_aw_done_d;
  logic                r_w_done, w_w_done_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic [STRB_W-1:0]   r_strb, w_strb_d;
  logic                w_busy;
  logic                w_tmo_hit;
  logic                w_aw_fin;
  logic                w_w_fin;

  assign w_busy    = (r_state != StIdle) && (r_state != StDone);
  assign w_tmo_hit = (TMO_CYC != 0) && (r_tmo == TMO_LIM);

  // Request fields are latched in IDLE so the bus sees stable values even if the cpu moves on.
  assign o_araddr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_awaddr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_strb;
  assign o_cpu_rdata = r_rdata;

  always_comb begin
    w_state_d   = r_state;
    w_rdata_d   = r_rdata;
    w_err_d     = r_err;
    w_aw_done_d = r_aw_done;
    w_w_done_d  = r_w_done;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_strb_d    = r_strb;
    w_aw_fin    = 1'b0;
    w_w_fin     = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_cpu_err   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cpu_cs) begin
          w_addr_d  = i_cpu_addr;
          w_wdata_d = i_cpu_wdata;
          w_strb_d  = ~i_cpu_web;
          w_err_d   = 1'b0;
          w_state_d = (&i_cpu_web) ? StRdA : StWr;
        end
      end
      StRdA: begin
        o_arvalid = 1'b1;
        if (i_arready) begin
          w_state_d = StRdD;
        end else if (w_tmo_hit) begin
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StRdD: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          w_rdata_d = i_rdata;
          w_err_d   = |i_rresp;
          w_state_d = StDone;
        end else if (w_tmo_hit) begin
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StWr: begin
        o_awvalid   = ~r_aw_done;
        o_wvalid    = ~r_w_done;
        w_aw_fin    = r_aw_done | i_awready;
        w_w_fin     = r_w_done | i_wready;
        w_aw_done_d = w_aw_fin;
        w_w_done_d  = w_w_fin;
        if (w_aw_fin && w_w_fin) begin
          w_state_d = StWrB;
        end else if (w_tmo_hit) begin
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StWrB: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          w_err_d   = |i_bresp;
          w_state_d = StDone;
        end else if (w_tmo_hit) begin
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        o_cpu_err   = r_err;
        w_aw_done_d = 1'b0;
        w_w_done_d  = 1'b0;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Counter restarts on every state change so each handshake gets its own budget.
    if (!w_busy || (w_state_d != r_state)) begin
      w_tmo_d = '0;
    end else begin
      w_tmo_d = r_tmo + TMO_W'(1);
    end
  end

  assign o_cpu_stall = i_rst_n & i_cpu_cs & (r_state != StDone);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_rdata   <= w_rdata_d;
      r_err     <= w_err_d;
      r_tmo     <= w_tmo_d;
      r_aw_done <= w_aw_done_d;
      r_w_done  <= w_w_done_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_strb    <= w_strb_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: hand-driven slave responses, cycle-by-cycle expectations.
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cs;
  logic [3:0]  cpu_web;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TMO_CYC(8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cpu_cs   (cpu_cs),
    .i_cpu_web  (cpu_web),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata),
    .o_cpu_stall(cpu_stall),
    .o_cpu_err  (cpu_err),
    .o_araddr   (araddr),
    .o_arvalid  (arvalid),
    .i_arready  (arready),
    .i_rdata    (rdata),
    .i_rresp    (rresp),
    .i_rvalid   (rvalid),
    .o_rready   (rready),
    .o_awaddr   (awaddr),
    .o_awvalid  (awvalid),
    .i_awready  (awready),
    .o_wdata    (wdata),
    .o_wstrb    (wstrb),
    .o_wvalid   (wvalid),
    .i_wready   (wready),
    .i_bresp    (bresp),
    .i_bvalid   (bvalid),
    .o_bready   (bready)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; cpu_cs = 1; cpu_web = 4'h0; cpu_addr = 32'h100; cpu_wdata = 32'h1;
    slave_idle();
    #2;
    n_tot++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", cpu_stall); else n_pass++;
    n_tot++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); else n_pass++;
    n_tot++; if ({arvalid, rready, awvalid, wvalid, bready, cpu_err} !== 6'b0)
      $display("FAIL rst_handshake got=%b exp=000000", {arvalid, rready, awvalid, wvalid, bready, cpu_err});
    else n_pass++;
    next_cycle();
    cpu_cs = 0;
    next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_read();
    cpu_cs = 1; cpu_web = 4'hF; cpu_addr = 32'h0000_1006;
    arready = 1; rvalid = 1; rdata = 32'hDEADBEEF; rresp = 0;
    @(negedge clk);  // IDLE
    n_tot++; if (cpu_stall !== 1'b1) $display("FAIL rd_idle_stall got=%0b exp=1", cpu_stall); else n_pass++;
    n_tot++; if (arvalid !== 1'b0) $display("FAIL rd_idle_arvalid got=%0b exp=0", arvalid); else n_pass++;
    next_cycle(); @(negedge clk);  // RD_A
    n_tot++; if (arvalid !== 1'b1) $display("FAIL rd_arvalid got=%0b exp=1", arvalid); else n_pass++;
    n_tot++; if (araddr !== 32'h0000_1004) $display("FAIL rd_araddr got=%h exp=00001004", araddr); else n_pass++;
    n_tot++; if (cpu_stall !== 1'b1) $display("FAIL rd_a_stall got=%0b exp=1", cpu_stall); else n_pass++;
    next_cycle(); @(negedge clk);  // RD_D
    n_tot++; if ({rready, arvalid} !== 2'b10) $display("FAIL rd_rready got=%b exp=10", {rready, arvalid}); else n_pass++;
    n_tot++; if (cpu_stall !== 1'b1) $display("FAIL rd_d_stall got=%0b exp=1", cpu_stall); else n_pass++;
    next_cycle(); @(negedge clk);  // DONE
    n_tot++; if (cpu_stall !== 1'b0) $display("FAIL rd_done_stall got=%0b exp=0", cpu_stall); else n_pass++;
    n_tot++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", cpu_rdata); else n_pass++;
    n_tot++; if (cpu_err !== 1'b0) $display("FAIL rd_err got=%0b exp=0", cpu_err); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle();
    @(negedge clk);  // IDLE, data held
    n_tot++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL rd_hold got=%h exp=deadbeef", cpu_rdata); else n_pass++;
    next_cycle();
  endtask

  task automatic test_write_aw_late();
    cpu_cs = 1; cpu_web = 4'b1100; cpu_addr = 32'h2000; cpu_wdata = 32'h12345678;
    wready = 1; awready = 0; bvalid = 1; bresp = 0;
    next_cycle(); @(negedge clk);  // WR c1: W handshake
    n_tot++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wr_c1_valid got=%b exp=11", {awvalid, wvalid}); else n_pass++;
    n_tot++; if (wstrb !== 4'b0011) $display("FAIL wr_strb got=%b exp=0011", wstrb); else n_pass++;
    n_tot++; if (wdata !== 32'h12345678) $display("FAIL wr_wdata got=%h exp=12345678", wdata); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); @(negedge clk);  // WR c2, c3: AW still pending
      n_tot++; if ({awvalid, wvalid} !== 2'b10) $display("FAIL wr_wait%0d got=%b exp=10", i, {awvalid, wvalid}); else n_pass++;
      n_tot++; if (awaddr !== 32'h2000) $display("FAIL wr_awaddr%0d got=%h exp=00002000", i, awaddr); else n_pass++;
    end
    next_cycle();
    awready = 1;
    @(negedge clk);  // WR c4: AW handshake
    n_tot++; if (awvalid !== 1'b1) $display("FAIL wr_c4_awvalid got=%0b exp=1", awvalid); else n_pass++;
    next_cycle(); @(negedge clk);  // WR_B
    n_tot++; if ({bready, awvalid, wvalid} !== 3'b100) $display("FAIL wr_b got=%b exp=100", {bready, awvalid, wvalid}); else n_pass++;
    n_tot++; if (cpu_stall !== 1'b1) $display("FAIL wr_b_stall got=%0b exp=1", cpu_stall); else n_pass++;
    next_cycle(); @(negedge clk);  // DONE
    n_tot++; if ({cpu_stall, cpu_err, bready} !== 3'b000) $display("FAIL wr_done got=%b exp=000", {cpu_stall, cpu_err, bready}); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle();
    next_cycle();
  endtask

  task automatic test_write_same_cycle_err();
    cpu_cs = 1; cpu_web = 4'b0000; cpu_addr = 32'h3000; cpu_wdata = 32'hA5A5A5A5;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
    next_cycle(); @(negedge clk);  // WR
    n_tot++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wr2_valid got=%b exp=11", {awvalid, wvalid}); else n_pass++;
    n_tot++; if (wstrb !== 4'b1111) $display("FAIL wr2_strb got=%b exp=1111", wstrb); else n_pass++;
    next_cycle(); @(negedge clk);  // WR_B directly
    n_tot++; if ({bready, awvalid, wvalid} !== 3'b100) $display("FAIL wr2_b got=%b exp=100", {bready, awvalid, wvalid}); else n_pass++;
    next_cycle(); @(negedge clk);  // DONE
    n_tot++; if ({cpu_err, cpu_stall} !== 2'b10) $display("FAIL wr2_err got=%b exp=10", {cpu_err, cpu_stall}); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle();
    @(negedge clk);
    n_tot++; if (cpu_err !== 1'b0) $display("FAIL wr2_err_pulse got=%0b exp=0", cpu_err); else n_pass++;
    next_cycle();
  endtask

  task automatic test_timeout();
    cpu_cs = 1; cpu_web = 4'hF; cpu_addr = 32'h4000;
    slave_idle();
    next_cycle();  // leave IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tot++; if ({arvalid, cpu_stall} !== 2'b11) $display("FAIL tmo_wait%0d got=%b exp=11", i, {arvalid, cpu_stall}); else n_pass++;
      next_cycle();
    end
    @(negedge clk);  // DONE
    n_tot++; if ({cpu_stall, cpu_err, arvalid} !== 3'b010) $display("FAIL tmo_done got=%b exp=010", {cpu_stall, cpu_err, arvalid}); else n_pass++;
    n_tot++; if (cpu_rdata !== 32'h0) $display("FAIL tmo_rdata got=%h exp=0", cpu_rdata); else n_pass++;
    next_cycle();
    cpu_cs = 0;
    @(negedge clk);
    n_tot++; if ({arvalid, cpu_err} !== 2'b00) $display("FAIL tmo_after got=%b exp=00", {arvalid, cpu_err}); else n_pass++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cpu_cs = 1; cpu_web = 4'hF; cpu_addr = 32'h6008;
    arready = 1; rvalid = 1; rdata = 32'h11223344; rresp = 0;
    next_cycle(); next_cycle(); next_cycle(); @(negedge clk);  // DONE
    n_tot++; if (cpu_rdata !== 32'h11223344) $display("FAIL b2b_rdata got=%h exp=11223344", cpu_rdata); else n_pass++;
    next_cycle();
    cpu_web = 4'b0101; cpu_addr = 32'h7000; cpu_wdata = 32'hCAFEF00D;
    slave_idle(); awready = 1; wready = 1; bvalid = 1;
    @(negedge clk);  // IDLE gap
    n_tot++; if ({cpu_stall, awvalid, wvalid} !== 3'b100) $display("FAIL b2b_gap got=%b exp=100", {cpu_stall, awvalid, wvalid}); else n_pass++;
    next_cycle();
    cpu_addr = 32'hFFFF_FFF0; cpu_web = 4'b1110; cpu_wdata = 32'h0;  // cpu moves on
    @(negedge clk);  // WR
    n_tot++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL b2b_wr got=%b exp=11", {awvalid, wvalid}); else n_pass++;
    n_tot++; if (awaddr !== 32'h7000) $display("FAIL b2b_awaddr got=%h exp=00007000", awaddr); else n_pass++;
    n_tot++; if (wstrb !== 4'b1010) $display("FAIL b2b_strb got=%b exp=1010", wstrb); else n_pass++;
    n_tot++; if (wdata !== 32'hCAFEF00D) $display("FAIL b2b_wdata got=%h exp=cafef00d", wdata); else n_pass++;
    next_cycle(); next_cycle(); @(negedge clk);  // DONE
    n_tot++; if ({cpu_stall, cpu_err} !== 2'b00) $display("FAIL b2b_done got=%b exp=00", {cpu_stall, cpu_err}); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle();
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    cpu_cs = 1; cpu_web = 4'b0000; cpu_addr = 32'h5000; cpu_wdata = 32'h5;
    awready = 1; wready = 1; bvalid = 0;
    next_cycle(); next_cycle(); @(negedge clk);  // WR_B
    n_tot++; if (bready !== 1'b1) $display("FAIL mrst_bready got=%0b exp=1", bready); else n_pass++;
    #1 rst_n = 0;
    #1;
    n_tot++; if ({bready, cpu_stall, arvalid, awvalid, wvalid, rready, cpu_err} !== 7'b0)
      $display("FAIL mrst_outs got=%b exp=0000000", {bready, cpu_stall, arvalid, awvalid, wvalid, rready, cpu_err});
    else n_pass++;
    n_tot++; if (cpu_rdata !== 32'h0) $display("FAIL mrst_rdata got=%h exp=0", cpu_rdata); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle(); bvalid = 1;
    rst_n = 1;
    @(negedge clk);  // IDLE, stray bvalid ignored
    n_tot++; if ({bready, cpu_stall} !== 2'b00) $display("FAIL mrst_idle got=%b exp=00", {bready, cpu_stall}); else n_pass++;
    next_cycle();
    bvalid = 0;
    cpu_cs = 1; cpu_web = 4'hF; cpu_addr = 32'h8000;
    arready = 1; rvalid = 1; rdata = 32'h0BADF00D;
    next_cycle(); @(negedge clk);  // RD_A
    n_tot++; if ({arvalid, araddr} !== {1'b1, 32'h8000}) $display("FAIL mrst_rd_a got=%b/%h exp=1/00008000", arvalid, araddr); else n_pass++;
    next_cycle(); next_cycle(); @(negedge clk);  // DONE
    n_tot++; if (cpu_rdata !== 32'h0BADF00D) $display("FAIL mrst_rd_data got=%h exp=0badf00d", cpu_rdata); else n_pass++;
    n_tot++; if ({cpu_stall, cpu_err} !== 2'b00) $display("FAIL mrst_rd_done got=%b exp=00", {cpu_stall, cpu_err}); else n_pass++;
    next_cycle();
    cpu_cs = 0; slave_idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_aw_late();
    test_write_same_cycle_err();
    test_timeout();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
